// File: rtl/mem_data_arbiter.sv
// Arbitrates the single-port data memory between the core (priority) and an external requester.
// Optional statistics counters are enabled with `define MEM_DATA_ARBITER_STATS_EN.
module mem_data_arbiter #(
    parameter int unsigned p_WORD_LEN   = 16,
    parameter int unsigned p_ADDR_LEN   = 10,
    parameter int unsigned p_STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_c_req,
    input  logic [15:0]           i_c_addr,
    input  logic                  i_c_wr_en,
    input  logic [p_WORD_LEN-1:0] i_c_wr_data,
    output logic                  o_c_stall,
    output logic                  o_c_rd_valid,
    output logic [p_WORD_LEN-1:0] o_c_rd_data,
    input  logic                  i_e_req,
    input  logic [15:0]           i_e_addr,
    input  logic                  i_e_wr_en,
    input  logic [p_WORD_LEN-1:0] i_e_wr_data,
    output logic                  o_e_ack,
    output logic                  o_e_rd_valid,
    output logic [p_WORD_LEN-1:0] o_e_rd_data,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic                  o_mem_wr_en,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data
`ifdef MEM_DATA_ARBITER_STATS_EN
    ,
    output logic [15:0]           o_stat_c_stall_cnt,
    output logic [15:0]           o_stat_e_grant_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_EXT  = 2'd2
    } tag_e;

    tag_e                  tag_q, tag_d;
    logic                  rng_q, rng_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [p_WORD_LEN-1:0] c_rd_data_q, c_rd_data_d;
    logic [p_WORD_LEN-1:0] e_rd_data_q, e_rd_data_d;

    logic                  c_grant;
    logic                  e_grant;
    logic                  starve_hit;
    logic                  in_range;
    logic                  sel_wr_en;
    logic [ADDR_W-1:0]     sel_addr;
    logic [p_WORD_LEN-1:0] sel_wr_data;
    logic [p_WORD_LEN-1:0] rsp_data;

    // Grant, memory-side mux and response/starvation next state
    always_comb begin
        starve_hit   = i_e_req && (starve_cnt_q == CNT_W'(p_STARVE_MAX));
        c_grant      = i_c_req && !starve_hit;
        e_grant      = i_e_req && !c_grant;
        sel_addr     = '0;
        sel_wr_en    = 1'b0;
        sel_wr_data  = '0;
        if (c_grant) begin
            sel_addr    = i_c_addr;
            sel_wr_en   = i_c_wr_en;
            sel_wr_data = i_c_wr_data;
        end else if (e_grant) begin
            sel_addr    = i_e_addr;
            sel_wr_en   = i_e_wr_en;
            sel_wr_data = i_e_wr_data;
        end
        in_range      = (sel_addr >> p_ADDR_LEN) == '0;
        o_mem_addr    = sel_addr[p_ADDR_LEN-1:0];
        o_mem_wr_data = sel_wr_data;
        o_mem_wr_en   = sel_wr_en && in_range;
        o_c_stall     = i_c_req && !c_grant;
        o_e_ack       = e_grant;

        tag_d = TAG_NONE;
        rng_d = 1'b0;
        if (c_grant && !i_c_wr_en) begin
            tag_d = TAG_CORE;
            rng_d = in_range;
        end else if (e_grant && !i_e_wr_en) begin
            tag_d = TAG_EXT;
            rng_d = in_range;
        end

        starve_cnt_d = starve_cnt_q;
        if (!i_e_req || e_grant) begin
            starve_cnt_d = '0;
        end else if (c_grant && (starve_cnt_q < CNT_W'(p_STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        // Out-of-range reads return zero instead of aliased memory contents
        rsp_data     = rng_q ? i_mem_rd_data : '0;
        o_c_rd_valid = (tag_q == TAG_CORE);
        o_e_rd_valid = (tag_q == TAG_EXT);
        o_c_rd_data  = o_c_rd_valid ? rsp_data : c_rd_data_q;
        o_e_rd_data  = o_e_rd_valid ? rsp_data : e_rd_data_q;
        c_rd_data_d  = o_c_rd_data;
        e_rd_data_d  = o_e_rd_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_q        <= TAG_NONE;
            rng_q        <= 1'b0;
            starve_cnt_q <= '0;
            c_rd_data_q  <= '0;
            e_rd_data_q  <= '0;
        end else begin
            tag_q        <= tag_d;
            rng_q        <= rng_d;
            starve_cnt_q <= starve_cnt_d;
            c_rd_data_q  <= c_rd_data_d;
            e_rd_data_q  <= e_rd_data_d;
        end
    end

`ifdef MEM_DATA_ARBITER_STATS_EN
    logic [15:0] stat_c_stall_q, stat_c_stall_d;
    logic [15:0] stat_e_grant_q, stat_e_grant_d;

    // Saturating event counters
    always_comb begin
        stat_c_stall_d = stat_c_stall_q;
        stat_e_grant_d = stat_e_grant_q;
        if (o_c_stall && (stat_c_stall_q != 16'hFFFF)) stat_c_stall_d = stat_c_stall_q + 16'd1;
        if (e_grant && (stat_e_grant_q != 16'hFFFF)) stat_e_grant_d = stat_e_grant_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_c_stall_q <= '0;
            stat_e_grant_q <= '0;
        end else begin
            stat_c_stall_q <= stat_c_stall_d;
            stat_e_grant_q <= stat_e_grant_d;
        end
    end

    assign o_stat_c_stall_cnt = stat_c_stall_q;
    assign o_stat_e_grant_cnt = stat_e_grant_q;
`endif

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
Shares the single-port data memory (mem_data) between the pipelined core's data port and an external requester (program loader / debug port). The core has priority. A starvation counter guarantees the external port a slot. The block also returns read data to the owner of each read and suppresses out-of-range accesses. It sits between core, mem_data and the external requester in the top level.

Parameters:
p_WORD_LEN, 16, data word width
p_ADDR_LEN, 10, implemented memory address bits; valid range 0..2**p_ADDR_LEN-1
p_STARVE_MAX, 4, max consecutive core grants while external request is pending; range 1..15

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_c_req  in  1  core access request, held until granted
i_c_addr  in  16  core address
i_c_wr_en  in  1  core write (1) / read (0)
i_c_wr_data  in  p_WORD_LEN  core write data
o_c_stall  out  1  core request not granted this cycle (combinational)
o_c_rd_valid  out  1  core read data valid
o_c_rd_data  out  p_WORD_LEN  core read data
i_e_req  in  1  external request, held until o_e_ack
i_e_addr  in  16  external address
i_e_wr_en  in  1  external write/read
i_e_wr_data  in  p_WORD_LEN  external write data
o_e_ack  out  1  external request granted this cycle (combinational)
o_e_rd_valid  out  1  external read data valid
o_e_rd_data  out  p_WORD_LEN  external read data
o_mem_addr  out  p_ADDR_LEN  to mem_data
o_mem_wr_en  out  1  to mem_data
o_mem_wr_data  out  p_WORD_LEN  to mem_data
i_mem_rd_data  in  p_WORD_LEN  from mem_data, valid 1 cycle after address

Behaviour:
- Reset (i_rst_n low, asynchronous): starvation counter 0, response tag NONE, o_c_rd_valid=0, o_e_rd_valid=0, rd_data outputs 0. Reset mid-access drops any in-flight read; no valid pulse follows.
- Grant decision each cycle (combinational):
  - The core wins if i_c_req and not (i_e_req and starve_cnt==p_STARVE_MAX).
  - Otherwise the external port wins if i_e_req.
  - No request: idle, o_mem_wr_en=0.
- o_c_stall = i_c_req & ~core_granted. o_e_ack = ext_granted.
- Starvation counter:
  - Increments (saturating at p_STARVE_MAX) on each core grant while i_e_req=1.
  - Clears on an external grant or when i_e_req=0.
- Granted access drives o_mem_addr = addr[p_ADDR_LEN-1:0] and o_mem_wr_data.
  - o_mem_wr_en = wr_en & in_range, where in_range = addr < 2**p_ADDR_LEN (upper bits all zero).
  - An out-of-range write is silently dropped.
- Response state machine, tag register NONE / CORE / EXT, state held one cycle:
  - A granted read sets the tag to its owner and latches in_range.
  - Next cycle the owner's rd_valid=1. rd_data = i_mem_rd_data if the latched in_range is set, else 0. The other port's rd_valid=0.
  - rd_data holds its last value otherwise.
  - A write or idle cycle sets the tag to NONE.
- Back-to-back: a new grant in the same cycle as a response is legal. Throughput is 1 access/cycle.
- Simultaneous core and external requests with starve_cnt<p_STARVE_MAX: core granted, external waits and its inputs must stay stable.

Optional Feature:
Macro MEM_DATA_ARBITER_STATS_EN.
- Defined: adds outputs o_stat_c_stall_cnt (16) and o_stat_e_grant_cnt (16).
  - o_stat_c_stall_cnt counts cycles with o_c_stall=1; o_stat_e_grant_cnt counts external grants.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Core-only read: write 16'hBEEF to addr 5, then read addr 5 -> o_c_rd_valid pulses one cycle after grant with 16'hBEEF, o_c_stall=0 throughout.
- Out of range: core writes 16'h1234 to addr 1024 (p_ADDR_LEN=10), then reads 1024 -> o_mem_wr_en=0 on the write cycle, read returns 16'h0000.
- Starvation: core requests every cycle, external read held from cycle 0, p_STARVE_MAX=4 -> 4 core grants, then o_e_ack=1 with o_c_stall=1 on cycle 4, then core resumes.
- Interleaved ownership: core read addr 3 (16'h0003) then external read addr 7 (16'h0007) on consecutive cycles -> o_c_rd_valid then o_e_rd_valid on consecutive cycles, data not crossed.
- Reset mid-read: grant external read, assert i_rst_n low before the response edge -> o_e_rd_valid never pulses; after release all outputs are at reset values and the counter is 0.
- Stats (macro defined): 3 forced core stalls plus 2 external grants -> o_stat_c_stall_cnt=3, o_stat_e_grant_cnt=2.
